maxpool_stream: RTL and testbench

MAXPOOL_STREAM -- requirements
Module: maxpool_stream

---
 rtl/maxpool_stream.sv | 162 ++++++++++++++++
 tb/tb_maxpool_stream.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool_stream.sv
// Streaming POOL_K x POOL_K max-pool (stride POOL_K) over a raster-order IMG_W x IMG_H feature map.
// Latency: result registered 1 cycle after the window-completing pixel; frame_done 1 cycle after final result accepted.
// Backpressure: single-entry output register; in_ready = !out_valid || out_ready, so a held result stalls input.
// Optional build macro MAXPOOL_SIGNED_EN: compare pixels as two's-complement signed instead of unsigned.
module maxpool_stream #(
    parameter int DATA_WIDTH = 8,    // CNN datapath pixel width
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28,
    parameter int POOL_K     = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  frame_done
);

    localparam int OUT_W = IMG_W / POOL_K;
    localparam int OUT_H = IMG_H / POOL_K;
    localparam int KW    = $clog2(POOL_K);
    localparam int JW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int RW    = (OUT_H > 1) ? $clog2(OUT_H) : 1;

    // Reject geometries where windows would not tile the image exactly.
    generate
        if (POOL_K < 2 || (IMG_W % POOL_K) != 0 || (IMG_H % POOL_K) != 0) begin : g_bad_cfg
            $error("maxpool_stream: POOL_K must be >= 2 and divide IMG_W and IMG_H");
        end
    endgenerate

    // The pixel position is kept split: col = ocol*POOL_K + kcol, row = orow*POOL_K + krow.
    // This gives the buffer index and window phase directly, without dividers.
    logic [KW-1:0]         kcol_q, kcol_d;
    logic [KW-1:0]         krow_q, krow_d;
    logic [JW-1:0]         ocol_q, ocol_d;
    logic [RW-1:0]         orow_q, orow_d;

    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_last_q, out_last_d;    // held result is the last one of its frame
    logic                  frame_done_q, frame_done_d;

    // One running maximum per output column of the current band of rows.
    logic [DATA_WIDTH-1:0] pbuf_q [OUT_W];

    logic                  in_fire;
    logic                  out_fire;
    logic                  win_start;
    logic                  win_end;
    logic                  frame_end;
    logic [DATA_WIDTH-1:0] buf_rd;
    logic [DATA_WIDTH-1:0] win_max;

    function automatic logic pix_gt(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
`ifdef MAXPOOL_SIGNED_EN
        return $signed(a) > $signed(b);
`else
        return a > b;
`endif
    endfunction

    // Handshakes, window phase decode and the running-max datapath.
    always_comb begin
        in_ready  = !out_valid_q || out_ready;
        in_fire   = in_valid && in_ready;
        out_fire  = out_valid_q && out_ready;
        win_start = (kcol_q == '0) && (krow_q == '0);
        win_end   = (kcol_q == KW'(POOL_K - 1)) && (krow_q == KW'(POOL_K - 1));
        frame_end = win_end && (ocol_q == JW'(OUT_W - 1)) && (orow_q == RW'(OUT_H - 1));
        buf_rd    = pbuf_q[ocol_q];
        // A window start overwrites whatever the previous band left behind.
        if (win_start) begin
            win_max = in_data;
        end else if (pix_gt(in_data, buf_rd)) begin
            win_max = in_data;
        end else begin
            win_max = buf_rd;
        end
    end

    // Raster position advance on every accepted pixel.
    always_comb begin
        kcol_d = kcol_q;
        krow_d = krow_q;
        ocol_d = ocol_q;
        orow_d = orow_q;
        if (in_fire) begin
            if (kcol_q == KW'(POOL_K - 1)) begin
                kcol_d = '0;
                if (ocol_q == JW'(OUT_W - 1)) begin
                    ocol_d = '0;
                    if (krow_q == KW'(POOL_K - 1)) begin
                        krow_d = '0;
                        orow_d = (orow_q == RW'(OUT_H - 1)) ? '0 : orow_q + 1'b1;
                    end else begin
                        krow_d = krow_q + 1'b1;
                    end
                end else begin
                    ocol_d = ocol_q + 1'b1;
                end
            end else begin
                kcol_d = kcol_q + 1'b1;
            end
        end
    end

    // Output register: load on window completion, drain on downstream accept.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        frame_done_d = out_fire && out_last_q;
        if (out_fire) begin
            out_valid_d = 1'b0;
        end
        // Cannot fire while a result is stuck, so the held data never changes under backpressure.
        if (in_fire && win_end) begin
            out_valid_d = 1'b1;
            out_data_d  = win_max;
            out_last_d  = frame_end;
        end
    end

    // Control state with asynchronous reset; a reset abandons any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kcol_q       <= '0;
            krow_q       <= '0;
            ocol_q       <= '0;
            orow_q       <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            kcol_q       <= kcol_d;
            krow_q       <= krow_d;
            ocol_q       <= ocol_d;
            orow_q       <= orow_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Partial-max buffer needs no reset: every window start overwrites its entry.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            pbuf_q[ocol_q] <= win_max;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_maxpool_stream.sv
module tb_maxpool_stream;

    localparam int DW   = 8;
    localparam int W    = 4;
    localparam int H    = 4;
    localparam int K    = 2;
    localparam int NPIX = W * H;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic          frame_done;

    maxpool_stream #(
        .DATA_WIDTH (DW),
        .IMG_W      (W),
        .IMG_H      (H),
        .POOL_K     (K)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [DW-1:0] val;
        int            cyc;
        bit            last;
    } exp_t;

    exp_t          sbq[$];
    int            n_pass = 0;
    int            n_total = 0;
    int            or_mode = 0;      // 0: always ready, 1: random, 2: never ready
    bit            gap_en = 0;
    int            pidx = 0;
    int            acc_cnt = 0;
    int            res_cnt = 0;
    int            fd_cnt = 0;
    logic [DW-1:0] last_data = '0;
    logic [DW-1:0] img [NPIX];
    logic [DW-1:0] fr [NPIX];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] pmax(input logic [DW-1:0] a, input logic [DW-1:0] b);
`ifdef MAXPOOL_SIGNED_EN
        return ($signed(a) >= $signed(b)) ? a : b;
`else
        return (a >= b) ? a : b;
`endif
    endfunction

    // Reference model: store the frame image; when a pixel completes a window,
    // take the max over the whole window from the stored image.
    task automatic model_accept(input logic [DW-1:0] d);
        int r;
        int c;
        logic [DW-1:0] m;
        exp_t e;
        img[pidx] = d;
        r = pidx / W;
        c = pidx % W;
        if ((r % K == K - 1) && (c % K == K - 1)) begin
            m = img[(r - K + 1) * W + (c - K + 1)];
            for (int dr = 0; dr < K; dr++)
                for (int dc = 0; dc < K; dc++)
                    m = pmax(m, img[(r - K + 1 + dr) * W + (c - K + 1 + dc)]);
            e.val  = m;
            e.cyc  = cyc;
            e.last = (pidx == NPIX - 1);
            sbq.push_back(e);
        end
        pidx = (pidx + 1) % NPIX;
        acc_cnt++;
    endtask

    task automatic send_pixel(input logic [DW-1:0] d);
        int t;
        if (gap_en) begin
            while ($urandom_range(0, 2) == 0) begin
                @(negedge clk);
                in_valid = 1'b0;
                in_data  = DW'($urandom);
            end
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        t = 0;
        forever begin
            #1;
            if (in_ready) begin
                @(posedge clk);
                #1;
                model_accept(d);
                break;
            end
            @(negedge clk);
            t++;
            if (t > 300) begin
                $display("FAIL in_ready_timeout: got stalled expected accept");
                $display("%0d/%0d checks passed", n_pass, n_total + 1);
                $fatal(1, "input stalled");
            end
        end
    endtask

    task automatic send_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) send_pixel(fr[i]);
    endtask

    task automatic drain();
        int t;
        @(negedge clk);
        in_valid = 1'b0;
        t = 0;
        while (sbq.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("drain_queue_empty", sbq.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_reset_vals();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_in_ready", in_ready, 1);
    endtask

    // Downstream ready generator.
    initial begin
        forever begin
            @(negedge clk);
            case (or_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: samples just before each rising edge, pops and compares on transfer.
    initial begin
        bit            prev_valid;
        bit            prev_fire;
        logic [DW-1:0] prev_data;
        bit            exp_fd;
        bit            fire;
        bit            new_res;
        exp_t          e;
        prev_valid = 0;
        prev_fire  = 0;
        prev_data  = '0;
        exp_fd     = 0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                prev_valid = 0;
                prev_fire  = 0;
                exp_fd     = 0;
            end else begin
                chk("frame_done", frame_done, exp_fd);
                if (frame_done) fd_cnt++;
                exp_fd = 0;
                chk("in_ready_rule", in_ready, !out_valid || out_ready);
                if (prev_valid && !prev_fire) begin
                    chk("hold_valid", out_valid, 1);
                    chk("hold_data", out_data, prev_data);
                end
                new_res = out_valid && (!prev_valid || prev_fire);
                if (new_res) begin
                    if (sbq.size() == 0) chk("unexpected_result", 1, 0);
                    else chk("latency_cycle", cyc, sbq[0].cyc);
                end
                fire = out_valid && out_ready;
                if (fire) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_transfer", 1, 0);
                    end else begin
                        e = sbq.pop_front();
                        chk("out_data", out_data, e.val);
                        exp_fd = e.last;
                    end
                    res_cnt++;
                    last_data = out_data;
                end
                prev_valid = out_valid;
                prev_fire  = fire;
                prev_data  = out_data;
            end
        end
    end

    initial begin
        int base_res;
        int base_fd;
        int base_acc;

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        chk_reset_vals();
        @(negedge clk);
        #3 rst_n = 1'b1;

        // Ramp frame then a random frame, back-to-back, always ready.
        for (int i = 0; i < NPIX; i++) fr[i] = DW'(i);
        base_res = res_cnt;
        base_fd  = fd_cnt;
        send_range(0, NPIX - 1);
        for (int i = 0; i < NPIX; i++) fr[i] = DW'($urandom);
        send_range(0, NPIX - 1);
        drain();
        chk("bb_result_count", res_cnt - base_res, 8);
        chk("bb_frame_done_count", fd_cnt - base_fd, 2);

        // Ramp frame with downstream blocked after first result.
        for (int i = 0; i < NPIX; i++) fr[i] = DW'(i);
        or_mode  = 2;
        base_acc = acc_cnt;
        fork
            send_range(0, NPIX - 1);
            begin
                repeat (25) @(negedge clk);
                #3;
                chk("bp_pixels_accepted", acc_cnt - base_acc, 6);
                chk("bp_out_valid", out_valid, 1);
                chk("bp_out_data", out_data, 5);
                chk("bp_in_ready", in_ready, 0);
                or_mode = 0;
            end
        join
        drain();

        // Sign-sensitive window.
        for (int i = 0; i < NPIX; i++) fr[i] = DW'($urandom);
        fr[0] = 8'h80;
        fr[1] = 8'h01;
        fr[4] = 8'h7F;
        fr[5] = 8'h00;
        send_range(0, 5);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
`ifdef MAXPOOL_SIGNED_EN
        chk("sign_window", last_data, 8'h7F);
`else
        chk("sign_window", last_data, 8'h80);
`endif
        send_range(6, NPIX - 1);
        drain();

        // Reset mid-frame.
        for (int i = 0; i < NPIX; i++) fr[i] = DW'(i);
        send_range(0, 5);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_reset_queue_empty", sbq.size(), 0);
        #3 rst_n = 1'b0;
        pidx = 0;
        sbq.delete();
        #1;
        chk_reset_vals();
        repeat (2) @(negedge clk);
        #3 rst_n = 1'b1;
        base_res = res_cnt;
        send_range(0, NPIX - 1);
        drain();
        chk("post_reset_result_count", res_cnt - base_res, 4);

        // Two flat frames with input gaps and random backpressure.
        for (int i = 0; i < NPIX; i++) fr[i] = 8'h3C;
        gap_en   = 1;
        or_mode  = 1;
        base_res = res_cnt;
        base_fd  = fd_cnt;
        send_range(0, NPIX - 1);
        send_range(0, NPIX - 1);
        drain();
        chk("flat_result_count", res_cnt - base_res, 8);
        chk("flat_frame_done_count", fd_cnt - base_fd, 2);

        // Random frames with gaps and backpressure.
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < NPIX; i++) fr[i] = DW'($urandom);
            send_range(0, NPIX - 1);
        end
        drain();

        chk("final_queue_empty", sbq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
